// File: rtl/instruction_fetch.sv
// Instruction fetch unit: a three-state FSM that requests one word per fetch,
// holds it for execution and advances the PC sequentially or by a taken branch.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        Branch,
  input  logic        Zero,
  input  logic [31:0] BranchOffset,
  input  logic        Stall,
  output logic [31:0] PC,
  output logic [31:0] Instr,
  output logic [6:0]  Opcode,
  output logic        InstrValid,
  output logic [31:0] InstrCount
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;

  logic [1:0]  state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] instr_reg, instr_next;
  logic [31:0] count_reg, count_next;

  logic        branch_taken;
  logic [31:0] pc_incr;
  logic [31:0] pc_target;

  // Branch inputs only reach state through the ISSUE/advance path below.
  assign branch_taken = Branch & Zero;
  assign pc_incr      = branch_taken ? BranchOffset : 32'd4;
  assign pc_target    = (pc_reg + pc_incr) & ~32'd3;

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    instr_next = instr_reg;
    count_next = count_reg;
    case (state_reg)
      IDLE: begin
        state_next = REQ;
      end
      REQ: begin
        if (imem_ack) begin
          instr_next = imem_rdata;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (!Stall) begin
          pc_next    = pc_target;
          count_next = count_reg + 32'd1;
          state_next = REQ;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
      instr_reg <= NOP_INSTR;
      count_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      count_reg <= count_next;
    end
  end

  // Handshake and valid decode from registered state only, so reset clears them at once.
  assign imem_req   = (state_reg == REQ);
  assign imem_addr  = pc_reg;
  assign InstrValid = (state_reg == ISSUE);
  assign PC         = pc_reg;
  assign Instr      = instr_reg;
  assign Opcode     = instr_reg[6:0];
  assign InstrCount = count_reg;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: reset, sequential and branch fetches,
// stalls, delayed acks, PC wrap and asynchronous abort of a pending fetch.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        Branch = 1'b0;
  logic        Zero = 1'b0;
  logic [31:0] BranchOffset = 32'd0;
  logic        Stall = 1'b0;
  logic [31:0] PC;
  logic [31:0] Instr;
  logic [6:0]  Opcode;
  logic        InstrValid;
  logic [31:0] InstrCount;

  int checks = 0;
  int errors = 0;

  instruction_fetch #(
    .RESET_PC (32'h0000_0000),
    .NOP_INSTR(32'h0000_0013)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .Branch      (Branch),
    .Zero        (Zero),
    .BranchOffset(BranchOffset),
    .Stall       (Stall),
    .PC          (PC),
    .Instr       (Instr),
    .Opcode      (Opcode),
    .InstrValid  (InstrValid),
    .InstrCount  (InstrCount)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Accept the pending request in the current cycle, then land in ISSUE.
  task automatic ack_now(input logic [31:0] word);
    imem_ack   = 1'b1;
    imem_rdata = word;
    $display("fetch addr=%h instr=%h", imem_addr, word);
    tick();
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
  endtask

  initial begin
    tick();
    tick();
    // Reset state
    check("rst_pc", PC, 32'h0);
    check("rst_instr", Instr, 32'h13);
    check("rst_opcode", {25'd0, Opcode}, 32'h13);
    check("rst_valid", {31'd0, InstrValid}, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_count", InstrCount, 32'd0);

    reset = 1'b0;
    check("idle_req", {31'd0, imem_req}, 32'd0);
    tick();
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'h0);
    check("first_valid", {31'd0, InstrValid}, 32'd0);
    ack_now(32'h0000_0033);
    check("f0_valid", {31'd0, InstrValid}, 32'd1);
    check("f0_opcode", {25'd0, Opcode}, 32'h33);
    check("f0_pc", PC, 32'h0);
    check("f0_req", {31'd0, imem_req}, 32'd0);
    check("f0_count", InstrCount, 32'd0);

    // Sequential fetches
    Branch = 1'b0; Zero = 1'b1; BranchOffset = 32'h40;
    tick();
    check("f1_addr", imem_addr, 32'h4);
    check("f1_req", {31'd0, imem_req}, 32'd1);
    ack_now(32'h0040_0093);
    check("f1_instr", Instr, 32'h0040_0093);
    tick();
    check("f2_addr", imem_addr, 32'h8);
    ack_now(32'h0080_0113);
    check("f2_valid", {31'd0, InstrValid}, 32'd1);
    check("f2_count", InstrCount, 32'd2);
    check("f2_pc", PC, 32'h8);

    // Taken branch forward to 0x10, then backward by -8
    Branch = 1'b1; Zero = 1'b1; BranchOffset = 32'h8;
    tick();
    check("br_fwd_addr", imem_addr, 32'h10);
    ack_now(32'h0000_0063);
    BranchOffset = 32'hFFFF_FFF8;
    tick();
    check("br_back_addr", imem_addr, 32'h8);

    // Delayed ack: branch inputs toggled in REQ must have no effect
    BranchOffset = 32'h1234_5670;
    for (int i = 0; i < 4; i++) begin
      check("dly_req", {31'd0, imem_req}, 32'd1);
      check("dly_addr", imem_addr, 32'h8);
      check("dly_valid", {31'd0, InstrValid}, 32'd0);
      tick();
    end
    check("dly_req_last", {31'd0, imem_req}, 32'd1);
    check("dly_addr_last", imem_addr, 32'h8);
    ack_now(32'h0000_0067);
    check("dly_issue", {31'd0, InstrValid}, 32'd1);
    check("dly_instr", Instr, 32'h0000_0067);
    check("dly_count", InstrCount, 32'd4);

    // Back to 0x10 then not-taken branch with Zero=0
    Branch = 1'b1; Zero = 1'b1; BranchOffset = 32'h8;
    tick();
    check("br_to10", imem_addr, 32'h10);
    ack_now(32'h0000_0063);
    Zero = 1'b0; BranchOffset = 32'hFFFF_FFF8;
    tick();
    check("br_nt_addr", imem_addr, 32'h14);
    ack_now(32'h00A0_0513);
    check("br_nt_count", InstrCount, 32'd6);

    // Stall in ISSUE; acks during ISSUE are ignored
    Stall = 1'b1; imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stl_valid", {31'd0, InstrValid}, 32'd1);
      check("stl_pc", PC, 32'h14);
      check("stl_instr", Instr, 32'h00A0_0513);
      check("stl_count", InstrCount, 32'd6);
      check("stl_req", {31'd0, imem_req}, 32'd0);
    end
    Stall = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; Branch = 1'b0;
    tick();
    check("stl_rel_req", {31'd0, imem_req}, 32'd1);
    check("stl_rel_addr", imem_addr, 32'h18);
    check("stl_rel_count", InstrCount, 32'd7);

    // Wrap: branch 0x18 -> 0xFFFFFFFC, then sequential wraps to 0
    ack_now(32'h0000_0013);
    Branch = 1'b1; Zero = 1'b1; BranchOffset = 32'hFFFF_FFE4;
    tick();
    check("wrap_top", imem_addr, 32'hFFFF_FFFC);
    ack_now(32'h0000_0013);
    Branch = 1'b0;
    tick();
    check("wrap_zero", imem_addr, 32'h0);
    check("wrap_count", InstrCount, 32'd9);

    // Low PC bits forced to zero on a misaligned offset
    ack_now(32'h0000_0013);
    Branch = 1'b1; Zero = 1'b1; BranchOffset = 32'h7;
    tick();
    check("align_addr", imem_addr, 32'h4);
    Branch = 1'b0;

    // Asynchronous reset while waiting in REQ
    tick();
    check("pre_rst_req", {31'd0, imem_req}, 32'd1);
    #3 reset = 1'b1;
    #1;
    check("async_req", {31'd0, imem_req}, 32'd0);
    check("async_pc", PC, 32'h0);
    check("async_count", InstrCount, 32'd0);
    check("async_instr", Instr, 32'h13);
    tick();
    reset = 1'b0;

    // Ack arriving in IDLE after reset must be ignored
    imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    check("abort_idle_req", {31'd0, imem_req}, 32'd0);
    tick();
    check("abort_instr", Instr, 32'h13);
    check("abort_req", {31'd0, imem_req}, 32'd1);
    check("abort_valid", {31'd0, InstrValid}, 32'd0);
    ack_now(32'h0000_006F);
    check("abort_opcode", {25'd0, Opcode}, 32'h6F);
    check("abort_pc", PC, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
